// File: rtl/prime_pkg.sv
// Shared types and constants for the iterative trial-division prime checker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prime_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SCREEN = 3'd1,
      DIV    = 3'd2,
      NEXT   = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Odd trial divisors start at 3 and advance by 2 (evens are screened out).
   localparam int unsigned FIRST_ODD_DIV = 3;
   localparam int unsigned DIV_STEP      = 2;

endpackage

// File: rtl/prime_rem_div.sv
// Restoring remainder unit: rem_o = n_i mod d_i, one quotient bit per cycle.
// Latency: WIDTH+1 cycles including the start cycle; done_o marks the cycle whose closing edge writes the final remainder.
// Backpressure: none; start_i is ignored while busy_o is high, rem_o holds until the next start.
module prime_rem_div #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] n_i,
   input  logic [WIDTH:0]   d_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH:0]   rem_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] num_q, num_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH:0]   div_q, div_d;
   logic             busy_q, busy_d;
   logic [WIDTH+1:0] trial;
   logic [WIDTH:0]   diff;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      cnt_d  = cnt_q;
      num_d  = num_q;
      rem_d  = rem_q;
      div_d  = div_q;
      busy_d = busy_q;
      trial  = {rem_q, num_q[WIDTH-1]};
      diff   = trial[WIDTH:0] - div_q;
      if (!busy_q) begin
         if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = CW'(WIDTH);
            num_d  = n_i;
            rem_d  = '0;
            div_d  = d_i;
         end
      end else begin
         rem_d = (trial >= {1'b0, div_q}) ? diff : trial[WIDTH:0];
         num_d = num_q << 1;
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
         end
      end
   end

   // Divider state; reset leaves the unit idle with a cleared remainder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         num_q  <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         num_q  <= num_d;
         rem_q  <= rem_d;
         div_q  <= div_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == CW'(1));
   assign rem_o  = rem_q;

endmodule

// File: rtl/prime_checker_iter.sv
// Iterative primality test by odd trial division up to sqrt(n); PRIME_FACTOR_OUT_EN adds out_factor.
// Latency: 2 + k*(WIDTH+2) cycles from accept to out_valid, k = number of trial divisors.
// Backpressure: one operand at a time; in_ready only in IDLE, result held until out_valid&&out_ready.
module prime_checker_iter
   import prime_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] number,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             is_prime,
   output logic [WIDTH-1:0] out_number
`ifdef PRIME_FACTOR_OUT_EN
   ,
   output logic [WIDTH-1:0] out_factor
`endif
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH:0]   d_q, d_d;
   logic             prime_q, prime_d;
`ifdef PRIME_FACTOR_OUT_EN
   logic [WIDTH-1:0] factor_q, factor_d;
`endif

   logic             div_start;
   logic             div_busy;
   logic             div_done;
   logic [WIDTH:0]   div_rem;

   // Candidate divisor for the next round and its square, both at widths that cannot overflow.
   logic [WIDTH:0]     cand;
   logic [2*WIDTH-1:0] cand_ext;
   logic [2*WIDTH-1:0] cand_sq;
   logic [2*WIDTH-1:0] n_ext;

   assign cand     = (state_q == SCREEN) ? (WIDTH+1)'(FIRST_ODD_DIV) : d_q + (WIDTH+1)'(DIV_STEP);
   assign cand_ext = {{(WIDTH-1){1'b0}}, cand};
   assign cand_sq  = cand_ext * cand_ext;
   assign n_ext    = {{WIDTH{1'b0}}, n_q};

   // The divider is kicked once on entry to DIV; busy masks the request afterwards.
   assign div_start = (state_q == DIV) && !div_busy;

   prime_rem_div #(
      .WIDTH (WIDTH)
   ) u_rem_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (div_start),
      .n_i     (n_q),
      .d_i     (d_q),
      .busy_o  (div_busy),
      .done_o  (div_done),
      .rem_o   (div_rem)
   );

   // Sequencing: screen trivial cases, then test odd divisors until one divides or d*d exceeds n.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      d_d     = d_q;
      prime_d = prime_q;
`ifdef PRIME_FACTOR_OUT_EN
      factor_d = factor_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               n_d     = number;
               state_d = SCREEN;
            end
         end
         SCREEN: begin
            prime_d = 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
            factor_d = '0;
`endif
            if (n_q < WIDTH'(2)) begin
               state_d = DONE;
            end else if (n_q == WIDTH'(2)) begin
               prime_d = 1'b1;
               state_d = DONE;
            end else if (!n_q[0]) begin
`ifdef PRIME_FACTOR_OUT_EN
               factor_d = WIDTH'(2);
`endif
               state_d = DONE;
            end else begin
               d_d = cand;
               if (cand_sq > n_ext) begin
                  prime_d = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = DIV;
               end
            end
         end
         DIV: begin
            if (div_done) begin
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (div_rem == '0) begin
               prime_d = 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
               factor_d = d_q[WIDTH-1:0];
`endif
               state_d = DONE;
            end else begin
               d_d = cand;
               if (cand_sq > n_ext) begin
                  prime_d = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = DIV;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and result registers; reset abandons any test in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         d_q     <= '0;
         prime_q <= 1'b0;
`ifdef PRIME_FACTOR_OUT_EN
         factor_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         d_q     <= d_d;
         prime_q <= prime_d;
`ifdef PRIME_FACTOR_OUT_EN
         factor_q <= factor_d;
`endif
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign is_prime   = prime_q;
   assign out_number = n_q;
`ifdef PRIME_FACTOR_OUT_EN
   assign out_factor = factor_q;
`endif

endmodule

// File: tb/tb_prime_checker_iter.sv
// Randomised and directed check of prime_checker_iter against a trial-division model.
// Latency: the model predicts 2 + k*(WIDTH+2) cycles per operand.
// Backpressure: out_ready is held low for random stretches while the result must stay stable.
module tb_prime_checker_iter;

   localparam int W = 8;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] number    = '0;
   logic         in_ready;
   logic         out_valid;
   logic         is_prime;
   logic [W-1:0] out_number;
`ifdef PRIME_FACTOR_OUT_EN
   logic [W-1:0] out_factor;
`endif

   int errs   = 0;
   int checks = 0;

   // Driver-owned expectation for the transaction identified by start_id.
   int start_id = 0;
   int exp_lat  = 0;
   int exp_n    = 0;
   int exp_f    = 0;
   bit exp_p    = 1'b0;

   // Monitor-owned tracking state.
   int cur_id  = 0;
   int done_id = 0;
   bit pend    = 1'b0;
   bit seen    = 1'b0;
   int lat     = 0;

   prime_checker_iter #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .number     (number),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .is_prime   (is_prime),
      .out_number (out_number)
`ifdef PRIME_FACTOR_OUT_EN
      ,
      .out_factor (out_factor)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Reference: plain trial division by odd d while d*d <= n; k counts divisors tried.
   function automatic void model(input int n, output bit p, output int f, output int k);
      k = 0;
      f = 0;
      p = 1'b0;
      if (n < 2) begin
         p = 1'b0;
      end else if (n == 2) begin
         p = 1'b1;
      end else if (n % 2 == 0) begin
         f = 2;
      end else begin
         p = 1'b1;
         for (int d = 3; d * d <= n; d += 2) begin
            k++;
            if (n % d == 0) begin
               p = 1'b0;
               f = d;
               break;
            end
         end
      end
   endfunction

   // Single compare process: handshake exclusivity every cycle, result/latency/stability while a result is due.
   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         chk("valid_ready_excl", int'(out_valid && in_ready), 0);
         if (start_id != cur_id) begin
            cur_id = start_id;
            pend   = 1'b1;
            seen   = 1'b0;
            lat    = 0;
         end
         if (pend) begin
            lat++;
            if (seen || out_valid) begin
               if (!seen) chk("latency", lat, exp_lat);
               else       chk("valid_held", int'(out_valid), 1);
               seen = 1'b1;
               chk("is_prime", int'(is_prime), int'(exp_p));
               chk("out_number", int'(out_number), exp_n);
`ifdef PRIME_FACTOR_OUT_EN
               chk("out_factor", int'(out_factor), exp_f);
`endif
               if (out_valid && out_ready) begin
                  pend    = 1'b0;
                  done_id = cur_id;
               end
            end else if (lat > exp_lat + 40) begin
               chk("latency_timeout", lat, exp_lat);
               pend    = 1'b0;
               done_id = cur_id;
            end
         end
      end
   end

   task automatic wait_in_ready();
      int b;
      b = 0;
      while (!in_ready && b < 300) begin
         @(posedge clk); #1;
         b++;
      end
      if (b >= 300) chk("in_ready_wait", int'(in_ready), 1);
   endtask

   task automatic set_expect(input int num);
      int k;
      model(num, exp_p, exp_f, k);
      exp_n   = num;
      exp_lat = 2 + k * (W + 2);
   endtask

   // Offer one operand, optionally stall the consumer for `hold` cycles while pulsing in_valid with 17.
   task automatic run(input int num, input int hold);
      int b;
      wait_in_ready();
      set_expect(num);
      in_valid  = 1'b1;
      number    = W'(num);
      out_ready = (hold == 0);
      @(posedge clk); #1;
      start_id++;
      in_valid = 1'b0;
      number   = W'($urandom);
      if (hold > 0) begin
         b = 0;
         while (!out_valid && b < 300) begin
            @(posedge clk); #1;
            b++;
         end
         for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            number   = W'(17);
            @(posedge clk); #1;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      b = 0;
      while (done_id != start_id && b < 300) begin
         @(posedge clk); #1;
         b++;
      end
      if (b >= 300) chk("done_wait", done_id, start_id);
   endtask

   initial begin
      bit mp;
      int mf, mk;
      int dir[12] = '{181, 175, 13, 0, 2, 1, 3, 4, 25, 49, 169, 255};

      // Pin the model with hand-worked results.
      model(181, mp, mf, mk);
      chk("model_181_p", int'(mp), 1);
      chk("model_181_k", mk, 6);
      model(175, mp, mf, mk);
      chk("model_175_f", mf, 5);
      chk("model_175_k", mk, 2);
      model(9, mp, mf, mk);
      chk("model_9_f", mf, 3);
      model(13, mp, mf, mk);
      chk("model_13_k", mk, 1);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_is_prime", int'(is_prime), 0);
      chk("reset_out_number", int'(out_number), 0);
`ifdef PRIME_FACTOR_OUT_EN
      chk("reset_out_factor", int'(out_factor), 0);
`endif
      @(posedge clk); #1;

      foreach (dir[i]) run(dir[i], 0);

      run(9, 10);

      // Reset while 181 is in its first DIV round.
      wait_in_ready();
      set_expect(181);
      in_valid = 1'b1;
      number   = W'(181);
      @(posedge clk); #1;
      start_id++;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out_number", int'(out_number), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run(255, 0);

      for (int i = 0; i < 60; i++) begin
         run(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
